// File: rtl/mdu_if.sv
// Issue/result bundle between the controller and the multiply/divide unit.
// Master drives start/op/operands/PC; slave returns busy and the HI/LO pair.
interface mdu_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] PC;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, op, A, B, PC, input busy, HI, LO);
   modport slave  (input start, op, A, B, PC, output busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// MIPS multiply/divide unit holding HI/LO; optional MDU_TRACE_EN prints every HI/LO write.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES, mthi/mtlo zero added cycles.
// Backpressure: busy stalls the controller; a start seen while busy is dropped, never queued.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
   logic        dz_q, dz_d;

   logic [63:0] prod_s, prod_u;
   logic [31:0] b_safe, a_mag, b_mag, qm, rm, q_s, r_s, q_u, r_u;

   // Low 64 bits of the sign-extended product equal the signed 32x32 result.
   always_comb begin
      prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
      prod_u = {32'd0, bus.A} * {32'd0, bus.B};
   end

   // Signed divide via magnitudes: avoids the -2^31/-1 overflow and yields
   // 0x80000000 naturally; a zero divisor is swapped for 1 and the result dropped.
   always_comb begin
      b_safe = (bus.B == 32'd0) ? 32'd1 : bus.B;
      a_mag  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
      b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
      qm     = a_mag / b_mag;
      rm     = a_mag % b_mag;
      q_s    = (bus.A[31] ^ b_safe[31]) ? (32'd0 - qm) : qm;
      r_s    = bus.A[31] ? (32'd0 - rm) : rm;
      q_u    = bus.A / b_safe;
      r_u    = bus.A % b_safe;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_tmp_d = hi_tmp_q;
      lo_tmp_d = lo_tmp_q;
      dz_d     = dz_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  3'd1: begin
                     hi_tmp_d = prod_s[63:32];
                     lo_tmp_d = prod_s[31:0];
                     dz_d     = 1'b0;
                     cnt_d    = MULT_N;
                     state_d  = BUSY;
                  end
                  3'd2: begin
                     hi_tmp_d = prod_u[63:32];
                     lo_tmp_d = prod_u[31:0];
                     dz_d     = 1'b0;
                     cnt_d    = MULT_N;
                     state_d  = BUSY;
                  end
                  3'd3: begin
                     hi_tmp_d = r_s;
                     lo_tmp_d = q_s;
                     dz_d     = (bus.B == 32'd0);
                     cnt_d    = DIV_N;
                     state_d  = BUSY;
                  end
                  3'd4: begin
                     hi_tmp_d = r_u;
                     lo_tmp_d = q_u;
                     dz_d     = (bus.B == 32'd0);
                     cnt_d    = DIV_N;
                     state_d  = BUSY;
                  end
                  3'd5:    hi_d = bus.A;
                  3'd6:    lo_d = bus.A;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               if (!dz_q) begin
                  hi_d = hi_tmp_q;
                  lo_d = lo_tmp_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_tmp_q <= 32'd0;
         lo_tmp_q <= 32'd0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_tmp_q <= hi_tmp_d;
         lo_tmp_q <= lo_tmp_d;
         dz_q     <= dz_d;
      end
   end

   assign bus.busy = (state_q == BUSY);
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

`ifdef MDU_TRACE_EN
   logic [31:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (state_q == IDLE && bus.start && bus.op >= 3'd1 && bus.op <= 3'd4)
         pc_d = bus.PC;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= 32'd0;
      else        pc_q <= pc_d;
   end

   always @(posedge clk) begin
      if (reset) begin
         if (state_q == IDLE && bus.start && bus.op == 3'd5)
            $display("@%h: $hi <= %h", bus.PC, bus.A);
         if (state_q == IDLE && bus.start && bus.op == 3'd6)
            $display("@%h: $lo <= %h", bus.PC, bus.A);
         if (state_q == BUSY && cnt_q == 4'd1 && !dz_q) begin
            $display("@%h: $hi <= %h", pc_q, hi_tmp_q);
            $display("@%h: $lo <= %h", pc_q, lo_tmp_q);
         end
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^bus.PC;
`endif

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected {HI,LO} queued at issue, compared at completion.
module tb_mdu;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;
   logic [31:0] cur_hi, cur_lo, pc_ctr;
   logic [63:0] sb_q[$];

   mdu_if bus ();

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic in 64-bit integers, independent of any divider structure.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = cur;
      case (op)
         3'd1: p = 64'(sa * sb);
         3'd2: p = {32'd0, a} * {32'd0, b};
         3'd3: if (b != 32'd0) begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
         end
         3'd4: if (b != 32'd0) p = {a % b, a / b};
         default: ;
      endcase
      return p;
   endfunction

   // Called at a negedge; the next posedge accepts the op.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit inject);
      int bc, n;
      logic [63:0] got;
      sb_q.push_back(exp);
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.PC    = pc_ctr;
      pc_ctr    = pc_ctr + 32'd4;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 3'd0;
      if (op == 3'd5 || op == 3'd6) begin
         chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
      end else begin
         n  = (op <= 3'd2) ? 5 : 10;
         bc = 0;
         while (bus.busy && bc < 40) begin
            bc++;
            if (inject && bc == 2) begin
               bus.start = 1'b1;
               bus.op    = 3'd6;
               bus.A     = 32'h0000DEAD;
            end else begin
               bus.start = 1'b0;
               bus.op    = 3'd0;
            end
            @(negedge clk);
         end
         bus.start = 1'b0;
         chk({tag, "_cycles"}, 64'(bc), 64'(n));
      end
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         got = sb_q.pop_front();
         chk(tag, {bus.HI, bus.LO}, got);
         {cur_hi, cur_lo} = got;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      n_chk     = 0;
      n_fail    = 0;
      cur_hi    = 32'd0;
      cur_lo    = 32'd0;
      pc_ctr    = 32'h0040_0000;
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.A     = 32'd0;
      bus.B     = 32'd0;
      bus.PC    = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Async reset in the middle of a divide discards the pending result.
      run_op("pre_mthi", 3'd5, 32'hAAAA5555, 32'd0, {32'hAAAA5555, cur_lo}, 1'b0);
      bus.start = 1'b1; bus.op = 3'd3; bus.A = 32'd100; bus.B = 32'd3;
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
      chk("midrst_hilo", {bus.HI, bus.LO}, 64'd0);
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("postrst_busy", {63'd0, bus.busy}, 64'd0);
      chk("postrst_hilo", {bus.HI, bus.LO}, 64'd0);

      run_op("mult_neg",  3'd1, 32'hFFFFFFFF, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFE}, 1'b0);
      run_op("multu",     3'd2, 32'hFFFFFFFF, 32'd2, {32'h00000001, 32'hFFFFFFFE}, 1'b0);
      run_op("div_neg",   3'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
      run_op("divu",      3'd4, 32'd7,        32'd2, {32'h00000001, 32'h00000003}, 1'b0);
      run_op("mthi",      3'd5, 32'h12345678, 32'd0, {32'h12345678, cur_lo},      1'b0);
      run_op("divu_zero", 3'd4, 32'd7,        32'd0, {cur_hi, cur_lo},            1'b0);
      run_op("mult_drop", 3'd1, 32'd3,        32'd4, {32'h0, 32'h0000000C},       1'b1);
      run_op("mult_b2b",  3'd1, 32'h00010000, 32'h00010000, {32'h1, 32'h0},       1'b0);
      run_op("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0);
      run_op("mtlo",      3'd6, 32'h0000CAFE, 32'd0, {cur_hi, 32'h0000CAFE},      1'b0);
      run_op("div_zero",  3'd3, 32'hFFFFFFFB, 32'd0, {cur_hi, cur_lo},            1'b0);

      // Reserved opcode 7 must act as none.
      bus.start = 1'b1; bus.op = 3'd7; bus.A = 32'h55555555;
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'd0;
      chk("op7_busy", {63'd0, bus.busy}, 64'd0);
      chk("op7_hilo", {bus.HI, bus.LO}, {cur_hi, cur_lo});

      for (int i = 0; i < 10; i++) begin
         rop = 3'($urandom_range(1, 4));
         ra  = $urandom;
         rb  = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
         if (i % 3 == 0) ra = -ra;
         run_op("rand", rop, ra, rb, model(rop, ra, rb, {cur_hi, cur_lo}), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the MIPS CPU datapath: executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` over multiple cycles and holds the HI/LO register pair. It sits beside the ALU in the execute path. Its HI/LO outputs are the `mfhi`/`mflo` sources that the write-back mux routes into the general register file's write-data port. While the unit is working, `busy` tells the controller to stall any later MDU instruction.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–15.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: qualifies `op` for one cycle.
- `op` input 3: operation code.
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 reserved, treated as none
- `A` input 32: rs operand.
- `B` input 32: rt operand.
- `PC` input 32: address of the issuing instruction, used only by trace.
- `busy` output 1: operation in flight.
- `HI` output 32: HI register.
- `LO` output 32: LO register.

## Operation
- States: IDLE, BUSY. A 4-bit down-counter `cnt` runs in BUSY.
- IDLE, `start` with op 1–4:
  - Compute the result combinationally from A/B and capture it into internal `hi_tmp`/`lo_tmp`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - HI/LO are unchanged at this point.
- BUSY: `cnt` decrements each edge. On the edge where `cnt`==1:
  - HI<=hi_tmp, LO<=lo_tmp.
  - Go to IDLE.
- IDLE, `start` with op 5 or 6: HI<=A (mthi) or LO<=A (mtlo) on that edge; stay IDLE.
- `start` while BUSY, any op: ignored. The controller guarantees a stall; the unit performs no queuing.
- Arithmetic:
  - mult: signed 32×32→64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32→64.
  - div: signed; LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div/divu with B==0): the full DIV_CYCLES busy period still runs, and HI/LO keep their previous values.
- `busy` is a registered output: high exactly when the state is BUSY.

## Timing
- Reset, asynchronous on `reset` low: HI=0, LO=0, busy=0, state IDLE, cnt=0. Takes effect mid-operation too; the pending result is discarded.
- Start at edge k (mult/div):
  - `busy` goes high after edge k.
  - HI/LO are updated and `busy` falls at edge k+N (N = MULT_CYCLES or DIV_CYCLES).
  - `busy` is high for exactly N cycles.
- A new start is accepted in the cycle right after `busy` falls, i.e. at edge k+N+1 at the earliest. Back-to-back operations are legal.
- mthi/mtlo have zero added latency: the new value is visible on HI/LO right after the accepting edge.
- HI/LO outputs are driven directly from the registers. No combinational path from A/B to HI/LO.

## Configuration
- `MDU_TRACE_EN` defined:
  - Every HI/LO write prints `$display("@%h: $hi <= %h", PC_l, value)` or the same format with `$lo`.
  - A mult/div completion prints two lines, hi first.
  - `PC_l` is PC latched at start, or the current PC for mthi/mtlo.
  - Writes suppressed by divide-by-zero print nothing.
- `MDU_TRACE_EN` undefined: no PC latch and no display. The `PC` port remains but is unused. Functional behaviour is identical.

## Test plan
- Reset: assert `reset`=0 mid-div at cycle 3 of 10 → HI=LO=0 and busy=0 immediately. Release reset, wait 10 cycles → HI/LO stay 0.
- mult A=0xFFFFFFFF, B=2 → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=2 → LO=3, HI=1.
- Divide-by-zero: preload HI=0x12345678 via mthi, then divu A=7, B=0 → busy 10 cycles; HI remains 0x12345678 and LO is unchanged.
- Start during busy: issue mult 3×4, then at busy cycle 2 pulse start with mtlo A=0xDEAD → mtlo ignored. Final HI=0, LO=0x0000000C. A mult issued on the first cycle after busy falls is accepted.
- Overflow corner: div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. With `MDU_TRACE_EN`, two trace lines carry the PC latched at start.
